// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage RV32M multiply/divide unit.
// Multiply is shift-add and divide is restoring, one radix-2 step per clock.
// The pipeline front is stalled through hold_req_o while an operation runs.
// Optional macro MULDIV_FAST_MUL_EN: all multiplies finish in a single cycle
// using a combinational multiplier; division is unaffected.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_100MHz,
    input  logic                  rst,
    input  logic [31:0]           inst_i,
    input  logic [XLEN-1:0]       reg1_r_data_i,
    input  logic [XLEN-1:0]       reg2_r_data_i,
    input  logic                  reg_w_ena_i,
    input  logic [REG_ADDR_W-1:0] reg_w_addr_i,
    input  logic                  jump_ena_i,
    output logic                  hold_req_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       result_o,
    output logic                  reg_w_ena_o,
    output logic [REG_ADDR_W-1:0] reg_w_addr_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state_q;
    logic [2:0]              funct3_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic                    wen_q;
    logic                    negQuot_q;
    logic                    negRem_q;
    logic [CW-1:0]           cnt_q;
    logic [XLEN-1:0]         op_q;
    logic [2*XLEN-1:0]       acc_q;
    logic [2*XLEN-1:0]       acc_d;
    logic [XLEN-1:0]         result_q;

    // Instruction decode straight from the ID/EX register.
    logic [2:0]      funct3;
    logic            mdOp;
    logic            isMul;
    logic            signedA;
    logic            signedB;
    logic            sgnA;
    logic            sgnB;
    logic [XLEN-1:0] aMag;
    logic [XLEN-1:0] bMag;
    logic            divZero;
    logic            divOvf;
    logic            start;
    logic            unusedInstBits;

    assign funct3  = inst_i[14:12];
    assign mdOp    = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
    assign isMul   = ~funct3[2];
    // DIV/REM/MULH are fully signed, MULHSU only treats rs1 as signed.
    assign signedA = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    assign signedB = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    assign sgnA    = signedA && reg1_r_data_i[XLEN-1];
    assign sgnB    = signedB && reg2_r_data_i[XLEN-1];
    assign aMag    = sgnA ? -reg1_r_data_i : reg1_r_data_i;
    assign bMag    = sgnB ? -reg2_r_data_i : reg2_r_data_i;
    assign divZero = (reg2_r_data_i == '0);
    assign divOvf  = funct3[2] && !funct3[0]
                     && (reg1_r_data_i == {1'b1, {(XLEN-1){1'b0}}})
                     && (reg2_r_data_i == '1);
    assign start   = (state_q == IDLE) && mdOp && !jump_ena_i && !rst;
    assign unusedInstBits = ^{inst_i[24:15], inst_i[11:7]};

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fastProd;
    assign fastProd = (2*XLEN)'(aMag) * (2*XLEN)'(bMag);
`endif

    // Applies the final sign fix-up and picks the requested half of the result.
    function automatic logic [XLEN-1:0] finalize(input logic [2*XLEN-1:0] acc,
                                                 input logic [2:0] f3,
                                                 input logic negQuot,
                                                 input logic negRem);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quot;
        logic [XLEN-1:0]   rem;
        prod = negQuot ? -acc : acc;
        quot = negQuot ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = negRem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!f3[2]) begin
            finalize = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            finalize = f3[1] ? rem : quot;
        end
    endfunction

    // One radix-2 step: shift-add for multiply, restore-or-subtract for divide.
    logic [XLEN:0] mulSum;
    logic [XLEN:0] divShift;
    logic [XLEN:0] divDiff;
    logic          noBorrow;
    always_comb begin
        mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
        divShift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        divDiff  = divShift - {1'b0, op_q};
        noBorrow = (divShift >= {1'b0, op_q});
        if (!funct3_q[2]) begin
            acc_d = {mulSum, acc_q[XLEN-1:1]};
        end else begin
            acc_d = {(noBorrow ? divDiff[XLEN-1:0] : divShift[XLEN-1:0]),
                     acc_q[XLEN-2:0], noBorrow};
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q   <= IDLE;
            funct3_q  <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        funct3_q  <= funct3;
                        rd_q      <= reg_w_addr_i;
                        wen_q     <= reg_w_ena_i;
                        negQuot_q <= sgnA ^ sgnB;
                        negRem_q  <= sgnA;
                        if (!isMul && divZero) begin
                            state_q  <= DONE;
                            result_q <= funct3[1] ? reg1_r_data_i : '1;
                        end else if (!isMul && divOvf) begin
                            state_q  <= DONE;
                            result_q <= funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
                        end else if (isMul) begin
                            state_q  <= DONE;
                            result_q <= finalize(fastProd, funct3, sgnA ^ sgnB, sgnA);
`endif
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= CW'(XLEN-1);
                            op_q    <= isMul ? aMag : bMag;
                            acc_q   <= {{XLEN{1'b0}}, (isMul ? bMag : aMag)};
                        end
                    end
                end
                CALC: begin
                    if (jump_ena_i) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            state_q  <= DONE;
                            result_q <= finalize(acc_d, funct3_q, negQuot_q, negRem_q);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign hold_req_o   = start || ((state_q == CALC) && !jump_ena_i);
    assign done_o       = (state_q == DONE) && !jump_ena_i;
    assign result_o     = done_o ? result_q : '0;
    assign reg_w_ena_o  = done_o && wen_q;
    assign reg_w_addr_o = done_o ? rd_q : '0;

endmodule
